// File: rtl/program_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package program_loader_pkg;

  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned HEADER_BYTES   = 2;
  localparam int unsigned LEN_WIDTH      = HEADER_BYTES * BYTE_WIDTH;
  localparam int unsigned BYTES_PER_WORD = INSTR_WIDTH / BYTE_WIDTH;
  localparam int unsigned IDX_WIDTH      = 2;

  localparam logic [IDX_WIDTH-1:0] LAST_BYTE_IDX = IDX_WIDTH'(BYTES_PER_WORD - 1);

  // IDLE doubles as the header-high stage: it captures the first length byte.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  function automatic logic accepts_byte(input state_t s);
    return (s == IDLE) || (s == LEN_LO) || (s == DATA);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == LEN_LO) || (s == DATA) || (s == WRITE);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word shift register; word_ready marks the cycle after the last byte.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [BYTE_WIDTH-1:0]  in_byte,
  output logic [INSTR_WIDTH-1:0] word,
  output logic [IDX_WIDTH-1:0]   byte_idx,
  output logic                   word_ready
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word       <= '0;
      byte_idx   <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= shift && (byte_idx == LAST_BYTE_IDX);
      if (clear) begin
        word     <= '0;
        byte_idx <= '0;
      end else if (shift) begin
        word     <= {word[INSTR_WIDTH-BYTE_WIDTH-1:0], in_byte};
        byte_idx <= byte_idx + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian instruction stream into instruction memory,
// then releases the processor from reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   load_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   word_idx;
  logic [LEN_WIDTH-1:0]   next_idx;
  logic [LEN_WIDTH-1:0]   full_len;
  logic [IDX_WIDTH-1:0]   byte_idx;
  logic [INSTR_WIDTH-1:0] word;
  logic                   word_ready;
  logic                   accept;
  logic                   asm_clear;
  logic                   asm_shift;

  assign in_ready  = accepts_byte(state);
  assign busy      = is_busy(state);
  assign accept    = in_valid && in_ready;
  assign full_len  = {len[LEN_WIDTH-1:BYTE_WIDTH], in_data};
  assign next_idx  = word_idx + LEN_WIDTH'(1);
  assign asm_clear = (state == LEN_LO) && accept;
  assign asm_shift = (state == DATA) && accept;

  program_loader_word_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .shift      (asm_shift),
    .in_byte    (in_data),
    .word       (word),
    .byte_idx   (byte_idx),
    .word_ready (word_ready)
  );

  // The assembler's registered flag lines up exactly with the WRITE cycle.
  assign mem_we    = word_ready;
  assign mem_wdata = word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      word_idx  <= '0;
      mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len[LEN_WIDTH-1:BYTE_WIDTH] <= in_data;
            state                       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[BYTE_WIDTH-1:0] <= in_data;
            word_idx            <= '0;
            if (full_len == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else if (33'(full_len) > MAX_WORDS) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && (byte_idx == LAST_BYTE_IDX)) begin
            mem_addr <= ADDR_WIDTH'(BASE_ADDR + 32'(word_idx));
            state    <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= next_idx;
          if (next_idx == len) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DONE: begin
          if (load_req) begin
            state     <= IDLE;
            done      <= 1'b0;
            cpu_reset <= 1'b1;
          end
        end
        ERROR: begin
          if (load_req) begin
            state <= IDLE;
            error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: header table, directed sequences, randomized streams.
module tb_program_loader;

  localparam int unsigned AW   = 8;
  localparam int unsigned BASE = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          load_req = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];

  always @(negedge clock) begin
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       exp_done;
    logic       exp_error;
    logic       exp_busy;
    logic       exp_ready;
    logic       exp_cpu_reset;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    load_req = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(negedge clock);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  // Presents the stream with the chosen valid pattern; holds each byte until accepted.
  task automatic drive(input int mode, input bit rand_req, output int first_cyc, output bit ok);
    int idx   = 0;
    int spent = 0;
    bit tog   = 1'b1;
    bit v;
    first_cyc = -1;
    ok        = 1'b1;
    while (idx < stream.size()) begin
      @(negedge clock);
      spent++;
      if (spent > 20 * stream.size() + 100) begin
        ok = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = v ? stream[idx] : 8'($urandom);
      load_req = rand_req ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && in_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        idx++;
      end
    end
  endtask

  task automatic wait_end(output int low_cyc, output bit ok);
    low_cyc = -1;
    ok      = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      load_req = 1'b0;
      if (low_cyc < 0 && !cpu_reset) low_cyc = cyc;
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: length header decides outcome; word i goes to BASE+i, first byte in bits 31:24.
  task automatic run_case(input string tag, input int mode, input bit check_lat, input bit rand_req);
    int unsigned   n;
    int unsigned   cap;
    bit            exp_err;
    logic [31:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            first_cyc;
    int            low_cyc;
    bit            ok;
    n       = {stream[0], stream[1]};
    cap     = 1 << AW;
    exp_err = (n > cap - BASE);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(AW'(BASE + i));
        exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
      end
    end
    got_addr.delete();
    got_data.delete();
    drive(mode, rand_req, first_cyc, ok);
    chk({tag, ".drive_ok"}, 32'(ok), 32'd1);
    wait_end(low_cyc, ok);
    chk({tag, ".end_ok"}, 32'(ok), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'(!exp_err));
    chk({tag, ".error"}, 32'(error), 32'(exp_err));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    chk({tag, ".wcount"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk({tag, ".waddr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
      chk({tag, ".wdata"}, got_data[i], exp_data[i]);
    end
    if (check_lat && !exp_err)
      chk({tag, ".latency"}, 32'(low_cyc - first_cyc), 32'(2 + 5 * n));
  endtask

  initial begin
    int          fc;
    bit          ok;
    int unsigned n;
    int          mode;
    vecs[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    do_reset();
    chk("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'(BASE));
    chk("rst.mem_wdata", mem_wdata, 32'd0);

    // Header-only table: state reached right after the length is complete.
    foreach (vecs[k]) begin
      do_reset();
      got_data.delete();
      stream = '{vecs[k].hi, vecs[k].lo};
      drive(0, 1'b0, fc, ok);
      @(negedge clock);
      in_valid = 1'b0;
      chk("hdr.done", 32'(done), 32'(vecs[k].exp_done));
      chk("hdr.error", 32'(error), 32'(vecs[k].exp_error));
      chk("hdr.busy", 32'(busy), 32'(vecs[k].exp_busy));
      chk("hdr.in_ready", 32'(in_ready), 32'(vecs[k].exp_ready));
      chk("hdr.cpu_reset", 32'(cpu_reset), 32'(vecs[k].exp_cpu_reset));
      chk("hdr.no_write", 32'(got_data.size()), 32'd0);
    end

    do_reset();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    run_case("ex_cont", 0, 1'b1, 1'b0);
    if (got_data.size() == 2) begin
      chk("ex_cont.w0", got_data[0], 32'h20080005);
      chk("ex_cont.w1", got_data[1], 32'h01095020);
      chk("ex_cont.a1", 32'(got_addr[1]), 32'd1);
    end

    // Asynchronous reset mid-cycle must act before the next clock edge.
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("async.done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    run_case("ex_toggle", 1, 1'b0, 1'b0);

    pulse_load_req();
    chk("reload.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload.done", 32'(done), 32'd0);
    chk("reload.in_ready", 32'(in_ready), 32'd1);
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_case("reload", 0, 1'b1, 1'b0);
    if (got_data.size() == 1) chk("reload.w0", got_data[0], 32'hDEADBEEF);

    // Abort in the middle of word 0, then reload from a fresh header.
    do_reset();
    got_data.delete();
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    drive(0, 1'b0, fc, ok);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk("abort.no_write", 32'(got_data.size()), 32'd0);
    chk("abort.cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_case("after_abort", 0, 1'b0, 1'b0);

    do_reset();
    stream = '{8'h01, 8'h01};
    run_case("err_hdr", 0, 1'b0, 1'b0);
    chk("err_hdr.in_ready", 32'(in_ready), 32'd0);
    pulse_load_req();
    chk("err_clear.error", 32'(error), 32'd0);
    chk("err_clear.in_ready", 32'(in_ready), 32'd1);

    // Exactly fills memory: last write lands on the top address.
    do_reset();
    stream = '{8'h01, 8'h00};
    for (int i = 0; i < 1024; i++) stream.push_back(8'($urandom));
    run_case("full", 0, 1'b1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      if ((done || error) && $urandom_range(0, 1) == 1) pulse_load_req();
      else do_reset();
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = 300 + $urandom_range(0, 100);
        default: n = $urandom_range(1, 6);
      endcase
      stream = '{8'(n >> 8), 8'(n)};
      if (n <= (1 << AW) - BASE)
        for (int i = 0; i < int'(4 * n); i++) stream.push_back(8'($urandom));
      mode = $urandom_range(0, 2);
      run_case("rand", mode, mode == 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
